// File: rtl/sram_mem_controller.sv
// sram_mem_controller: MEM-stage data-memory controller. Splits one 32-bit
// load/store from the EX/MEM registers into two 16-bit SRAM accesses (low
// halfword first). While an access is in flight, ready stays low so the
// pipeline stays frozen.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   rdEn, wrEn       load / store request, held by the frozen pipeline
//   address          byte address (bits [1:0] ignored)
//   writeData        store data
//   readData         registered load result, feeds MEM/WB
//   ready            combinational; high when idle or on the completing cycle
//   sramAddr         SRAM halfword address
//   sramDqOut/In     SRAM data bus, out / in
//   sramDqOe         1 = controller drives DQ
//   sramWeN          SRAM write enable, active low
module sram_mem_controller #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdEn,
    input  logic        wrEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic [17:0] sramAddr,
    output logic [15:0] sramDqOut,
    input  logic [15:0] sramDqIn,
    output logic        sramDqOe,
    output logic        sramWeN
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 17;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [31:0]         data_q, data_d;
    logic [15:0]         lo_q, lo_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [17:0]         sram_addr_q, sram_addr_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                dq_oe_q, dq_oe_d;
    logic                we_n_q, we_n_d;

    logic [31:0]         offset_c;
    logic [WORD_W-1:0]   word_idx_c;
    logic                phase_last_c;

    // Word index relative to BASE_ADDR; addresses below the base wrap silently.
    assign offset_c     = address - 32'(BASE_ADDR);
    assign word_idx_c   = offset_c[18:2];
    assign phase_last_c = (cnt_q == CNT_LAST);

    assign ready     = ~(rdEn | wrEn) | (state_q == DONE);
    assign readData  = rdata_q;
    assign sramAddr  = sram_addr_q;
    assign sramDqOut = dq_out_q;
    assign sramDqOe  = dq_oe_q;
    assign sramWeN   = we_n_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            data_q      <= '0;
            lo_q        <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            data_q      <= data_d;
            lo_q        <= lo_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    // Next state, phase counter and load capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        data_d  = data_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wrEn) begin
                    word_d  = word_idx_c;
                    data_d  = writeData;
                    state_d = WR_LO;
                end else if (rdEn) begin
                    word_d  = word_idx_c;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                if (phase_last_c) begin
                    cnt_d   = '0;
                    lo_d    = sramDqIn;
                    state_d = RD_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_HI: begin
                if (phase_last_c) begin
                    cnt_d   = '0;
                    rdata_d = {sramDqIn, lo_q};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_LO: begin
                if (phase_last_c) begin
                    cnt_d   = '0;
                    state_d = WR_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_HI: begin
                if (phase_last_c) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // SRAM bus values decoded from the upcoming state so they register in step with it.
    always_comb begin
        sram_addr_d = '0;
        dq_out_d    = '0;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        unique case (state_d)
            RD_LO: sram_addr_d = {word_d, 1'b0};
            RD_HI: sram_addr_d = {word_d, 1'b1};
            WR_LO: begin
                sram_addr_d = {word_d, 1'b0};
                dq_out_d    = data_d[15:0];
                dq_oe_d     = 1'b1;
                we_n_d      = 1'b0;
            end
            WR_HI: begin
                sram_addr_d = {word_d, 1'b1};
                dq_out_d    = data_d[31:16];
                dq_oe_d     = 1'b1;
                we_n_d      = 1'b0;
            end
            default: begin
                sram_addr_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller: directed cases plus randomized
// load/store traffic compared with a halfword-array reference model.
module tb_sram_mem_controller;

    localparam int unsigned W    = 5;
    localparam int unsigned BASE = 1024;
    localparam int unsigned PER  = 10;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rdEn, wrEn;
    logic [31:0] address, writeData, readData;
    logic        ready;
    logic [17:0] sramAddr;
    logic [15:0] sramDqOut, sramDqIn;
    logic        sramDqOe, sramWeN;

    logic        rdEn1, wrEn1;
    logic [31:0] address1, writeData1, readData1;
    logic        ready1;
    logic [17:0] sramAddr1;
    logic [15:0] sramDqOut1, sramDqIn1;
    logic        sramDqOe1, sramWeN1;

    sram_mem_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .rdEn(rdEn), .wrEn(wrEn),
        .address(address), .writeData(writeData), .readData(readData),
        .ready(ready), .sramAddr(sramAddr), .sramDqOut(sramDqOut),
        .sramDqIn(sramDqIn), .sramDqOe(sramDqOe), .sramWeN(sramWeN)
    );

    sram_mem_controller #(.WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .rst(rst), .rdEn(rdEn1), .wrEn(wrEn1),
        .address(address1), .writeData(writeData1), .readData(readData1),
        .ready(ready1), .sramAddr(sramAddr1), .sramDqOut(sramDqOut1),
        .sramDqIn(sramDqIn1), .sramDqOe(sramDqOe1), .sramWeN(sramWeN1)
    );

    // SRAM model for the main instance; the W=1 instance reads an address-derived pattern.
    logic [15:0] sram [0:262143];
    int          wr_cnt = 0;
    int          ready_hi = 0;
    assign sramDqIn  = sram[sramAddr];
    assign sramDqIn1 = sramAddr1[15:0] ^ 16'h5A5A;

    always @(posedge clk) begin
        if (sramWeN === 1'b0) begin
            sram[sramAddr] <= sramDqOut;
            wr_cnt <= wr_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (ready === 1'b1) ready_hi <= ready_hi + 1;
    end

    int          checks = 0;
    int          failures = 0;
    logic [15:0] ref_mem [int];
    logic [31:0] exp_rdata = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int unsigned i);
        return 16'(i * 32'd40503 + 32'd17);
    endfunction

    function automatic int unsigned hw_base(input logic [31:0] a);
        return (((a - 32'(BASE)) >> 2) & 32'h1FFFF) * 2;
    endfunction

    function automatic logic [15:0] ref_rd(input int unsigned hw);
        if (ref_mem.exists(int'(hw))) return ref_mem[int'(hw)];
        return pat(hw);
    endfunction

    // Presents one request now (just after a rising edge), samples every cycle
    // until ready, then drops the request just after the completing edge.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int we_cnt, output int oe_cnt,
                          output logic [17:0] a_lo, output logic [17:0] a_hi,
                          output logic [31:0] rd_done);
        wrEn = wr; rdEn = rd; address = a; writeData = d;
        lat = -1; we_cnt = 0; oe_cnt = 0; a_lo = '0; a_hi = '0; rd_done = '0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (sramWeN === 1'b0) we_cnt++;
            if (sramDqOe === 1'b1) oe_cnt++;
            if (c == 1) a_lo = sramAddr;
            if (c == int'(W) + 1) a_hi = sramAddr;
            if (ready === 1'b1) begin
                lat = c;
                rd_done = readData;
                break;
            end
        end
        @(posedge clk); #1;
        wrEn = 1'b0; rdEn = 1'b0;
    endtask

    task automatic do_op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                         input string tag);
        int unsigned hw;
        int          lat, wec, oec;
        logic [17:0] alo, ahi;
        logic [31:0] rdd;
        hw = hw_base(a);
        access(wr, rd, a, d, lat, wec, oec, alo, ahi, rdd);
        check_eq({tag, ":latency"}, 32'(lat), 32'(2 * W + 1));
        check_eq({tag, ":addr_lo"}, 32'(alo), hw);
        check_eq({tag, ":addr_hi"}, 32'(ahi), hw + 1);
        if (wr) begin
            ref_mem[int'(hw)]     = d[15:0];
            ref_mem[int'(hw + 1)] = d[31:16];
            check_eq({tag, ":we_cycles"}, 32'(wec), 32'(2 * W));
            check_eq({tag, ":oe_cycles"}, 32'(oec), 32'(2 * W));
            check_eq({tag, ":sram_lo"}, 32'(sram[hw]), 32'(ref_rd(hw)));
            check_eq({tag, ":sram_hi"}, 32'(sram[hw + 1]), 32'(ref_rd(hw + 1)));
            check_eq({tag, ":rdata_kept"}, rdd, exp_rdata);
        end else begin
            exp_rdata = {ref_rd(hw + 1), ref_rd(hw)};
            check_eq({tag, ":we_cycles"}, 32'(wec), 0);
            check_eq({tag, ":oe_cycles"}, 32'(oec), 0);
            check_eq({tag, ":rdata"}, rdd, exp_rdata);
        end
    endtask

    task automatic access1(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output int we_cnt,
                           output logic [17:0] a_lo, output logic [17:0] a_hi,
                           output logic [15:0] dq_lo, output logic [15:0] dq_hi,
                           output logic [31:0] rd_done);
        wrEn1 = wr; rdEn1 = ~wr; address1 = a; writeData1 = d;
        lat = -1; we_cnt = 0; a_lo = '0; a_hi = '0; dq_lo = '0; dq_hi = '0; rd_done = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (sramWeN1 === 1'b0) we_cnt++;
            if (c == 1) begin a_lo = sramAddr1; dq_lo = sramDqOut1; end
            if (c == 2) begin a_hi = sramAddr1; dq_hi = sramDqOut1; end
            if (ready1 === 1'b1) begin
                lat = c;
                rd_done = readData1;
                break;
            end
        end
        @(posedge clk); #1;
        wrEn1 = 1'b0; rdEn1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          lat, wec, rc0, wc0;
        time         t0;
        logic [17:0] alo, ahi;
        logic [15:0] dlo, dhi;
        logic [31:0] rdd;

        rst = 1'b1; rdEn = 1'b0; wrEn = 1'b0; address = '0; writeData = '0;
        rdEn1 = 1'b0; wrEn1 = 1'b0; address1 = '0; writeData1 = '0;
        for (int i = 0; i < 262144; i++) sram[i] = pat(i);

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst:readData", readData, 32'h0);
        check_eq("rst:sramWeN", 32'(sramWeN), 1);
        check_eq("rst:sramDqOe", 32'(sramDqOe), 0);
        check_eq("rst:ready", 32'(ready), 1);
        check_eq("rst:sramAddr", 32'(sramAddr), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed store, load, simultaneous request.
        do_op(1'b1, 1'b0, 32'h408, 32'hDEADBEEF, "store");
        check_eq("store:sram4", 32'(sram[4]), 32'h0000BEEF);
        check_eq("store:sram5", 32'(sram[5]), 32'h0000DEAD);
        do_op(1'b0, 1'b1, 32'h408, 32'h0, "load");
        check_eq("load:value", readData, 32'hDEADBEEF);
        do_op(1'b1, 1'b1, 32'h400, 32'h12345678, "both");
        check_eq("both:sram0", 32'(sram[0]), 32'h00005678);
        check_eq("both:sram1", 32'(sram[1]), 32'h00001234);

        // Back-to-back store then load, no idle gap between them.
        t0  = $time;
        rc0 = ready_hi;
        do_op(1'b1, 1'b0, 32'h40C, 32'hA1B2C3D4, "b2b_st");
        do_op(1'b0, 1'b1, 32'h40C, 32'h0, "b2b_ld");
        check_eq("b2b:cycles", 32'(($time - t0) / PER), 24);
        check_eq("b2b:ready_pulses", 32'(ready_hi - rc0), 2);
        check_eq("b2b:value", readData, 32'hA1B2C3D4);

        // Reset on the fourth cycle of RD_LO.
        wc0 = wr_cnt;
        rdEn = 1'b1; address = 32'h410;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; rdEn = 1'b0;
        @(negedge clk);
        check_eq("midrst:addr_before", 32'(sramAddr), hw_base(32'h410));
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("midrst:sramAddr", 32'(sramAddr), 0);
        check_eq("midrst:readData", readData, 32'h0);
        check_eq("midrst:sramWeN", 32'(sramWeN), 1);
        check_eq("midrst:sramDqOe", 32'(sramDqOe), 0);
        check_eq("midrst:ready", 32'(ready), 1);
        check_eq("midrst:no_writes", 32'(wr_cnt - wc0), 0);
        exp_rdata = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            int unsigned op, gap;
            logic [31:0] a, d;
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) a = 32'(BASE) - 32'(4 * $urandom_range(1, 8));
            else                           a = 32'(BASE) + 32'(4 * $urandom_range(0, 31));
            a = a | 32'($urandom_range(0, 3));
            d = $urandom;
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            do_op(op != 0, op != 1, a, d, "rnd");
        end

        // Single-cycle phases and an address below the base.
        access1(1'b0, 32'h3FC, 32'h0, lat, wec, alo, ahi, dlo, dhi, rdd);
        check_eq("w1_rd:latency", 32'(lat), 3);
        check_eq("w1_rd:addr_lo", 32'(alo), 32'h3FFFE);
        check_eq("w1_rd:addr_hi", 32'(ahi), 32'h3FFFF);
        check_eq("w1_rd:rdata", rdd, 32'hA5A5A5A4);
        check_eq("w1_rd:we_cycles", 32'(wec), 0);
        access1(1'b1, 32'h3FC, 32'hCAFEF00D, lat, wec, alo, ahi, dlo, dhi, rdd);
        check_eq("w1_wr:latency", 32'(lat), 3);
        check_eq("w1_wr:we_cycles", 32'(wec), 2);
        check_eq("w1_wr:dq_lo", 32'(dlo), 32'h0000F00D);
        check_eq("w1_wr:dq_hi", 32'(dhi), 32'h0000CAFE);
        check_eq("w1_wr:addr_hi", 32'(ahi), 32'h3FFFF);
        check_eq("w1_wr:rdata_kept", rdd, 32'hA5A5A5A4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- MEM-stage data-memory controller. Converts one 32-bit load/store from the EX/MEM pipeline registers into two 16-bit accesses on an external SRAM bus.
- Deasserts ready while an access is in flight. The top level uses ~ready to freeze every pipeline stage and pipeline register.
- Sits between the EX/MEM registers and the MEM/WB registers. readData feeds the MEM/WB registers.

Parameters:
- WAIT_CYCLES, 5: cycles each 16-bit SRAM phase is held. Legal range 1..15.
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- rdEn  in  1  load request, held by the frozen pipeline until ready
- wrEn  in  1  store request, held by the frozen pipeline until ready
- address  in  32  byte address; bits [1:0] are ignored
- writeData  in  32  store data
- readData  out  32  load result, registered
- ready  out  1  1 = no access pending or the current access completes this cycle
- sramAddr  out  18  SRAM halfword address
- sramDqOut  out  16  write data to the SRAM
- sramDqIn  in  16  read data from the SRAM
- sramDqOe  out  1  1 = controller drives the DQ bus
- sramWeN  out  1  SRAM write enable, active low

Behaviour:
- One clock domain. Synchronous active-high reset: clk, rst.
- State machine states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. A 4-bit wait counter cnt runs inside each phase.
- Reset values:
  - state = IDLE, cnt = 0, readData = 0
  - sramAddr = 0, sramDqOut = 0, sramDqOe = 0, sramWeN = 1
  - latched address and data registers = 0
- Reset taken in any state, including mid-access: next cycle is IDLE with all reset values. No partial write continues.
- IDLE:
  - wrEn = 1 (wrEn has priority over rdEn): latch address and writeData, go to WR_LO.
  - rdEn = 1 and wrEn = 0: latch address, go to RD_LO.
  - Neither asserted: stay in IDLE.
- Address mapping:
  - wordIdx = (address - BASE_ADDR) >> 2, computed modulo 2^32; keep bits [16:0].
  - LO phases drive sramAddr = {wordIdx, 0}. HI phases drive sramAddr = {wordIdx, 1}.
  - Addresses below BASE_ADDR wrap silently. There is no error flag.
- Each of RD_LO, RD_HI, WR_LO, WR_HI lasts exactly WAIT_CYCLES cycles:
  - cnt starts at 0 and increments every cycle.
  - The phase advances when cnt == WAIT_CYCLES-1; cnt then clears.
- Read phases:
  - sramDqOe = 0, sramWeN = 1.
  - On the last cycle of RD_LO, sample sramDqIn into an internal low-half register.
  - On the last cycle of RD_HI, load readData <= {sramDqIn, lowHalf}.
  - RD_HI advances to DONE.
- Write phases:
  - sramDqOe = 1, sramWeN = 0 on every cycle of the phase.
  - sramDqOut = writeData[15:0] in WR_LO and writeData[31:16] in WR_HI.
  - WR_HI advances to DONE.
- DONE:
  - Lasts one cycle, then always returns to IDLE.
  - sramWeN = 1, sramDqOe = 0.
  - readData holds its value until the next read completes. Writes do not change readData.
- ready is combinational: ready = ~(rdEn | wrEn) | (state == DONE).
- Latency:
  - Request first seen in IDLE = cycle 0.
  - ready is low for cycles 0..2*WAIT_CYCLES and high in cycle 2*WAIT_CYCLES+1 (DONE). The pipeline advances on that edge.
  - Default WAIT_CYCLES = 5: 11 stall cycles, with ready high in cycle 11.
- Back-to-back requests: a new request presented in the cycle after DONE is accepted in IDLE. Each access costs 2*WAIT_CYCLES+2 cycles.
- Request dropped mid-access (illegal, because the pipeline is frozen): the access still completes through DONE.

Test Plan:
- Reset: hold rst for 2 cycles -> readData = 0, sramWeN = 1, sramDqOe = 0, ready = 1 with no request. Then assert rst at cycle 4 of an RD_LO -> IDLE next cycle, and the SRAM model sees no access.
- Store: wrEn = 1, address = 0x408, writeData = 0xDEADBEEF, WAIT_CYCLES = 5 -> SRAM model receives addr 4 = 0xBEEF and addr 5 = 0xDEAD. sramWeN is low for exactly 10 cycles. ready is high in cycle 11 only, then wrEn drops.
- Load: preload SRAM addr 4 = 0xBEEF and addr 5 = 0xDEAD; rdEn = 1, address = 0x408 -> readData = 0xDEADBEEF on the DONE cycle. sramDqOe stays 0 throughout. ready is low for 11 cycles.
- Simultaneous rdEn = wrEn = 1, address = 0x400, writeData = 0x12345678 -> a write occurs: SRAM addr 0 = 0x5678, addr 1 = 0x1234. readData is unchanged.
- Back-to-back: a store then a load to the same address, each presented the cycle after the prior DONE -> the load returns the stored value. Total time = 24 cycles. ready pulses exactly twice.
- Boundary: WAIT_CYCLES = 1 -> ready goes high in cycle 3. Address 0x3FC (below BASE_ADDR) -> sramAddr = 0x3FFFE then 0x3FFFF.
